// File: rtl/trace_capture_if.sv
// Bus bundle for trace_capture: capture/trigger controls, readout pop port and status.
// The master side (producer/reader) drives controls; the slave side (trace buffer) reports status.
interface trace_capture_if #(
  parameter int unsigned REC_W = 105,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned TS_W  = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                    arm;
  logic [1:0]              mode;
  logic [AW-1:0]           post_cnt;
  logic                    rec_valid;
  logic [REC_W-1:0]        rec_data;
  logic                    trig;
  logic                    rd_en;
  logic [TS_W+REC_W-1:0]   rd_data;
  logic                    rd_valid;
  logic                    rd_empty;
  logic [AW:0]             count;
  logic                    overflow;
  logic [1:0]              state;

  modport master (
    output arm, mode, post_cnt, rec_valid, rec_data, trig, rd_en,
    input  rd_data, rd_valid, rd_empty, count, overflow, state
  );

  modport slave (
    input  arm, mode, post_cnt, rec_valid, rec_data, trig, rd_en,
    output rd_data, rd_valid, rd_empty, count, overflow, state
  );
endinterface

// File: rtl/trace_capture.sv
// Circular trace buffer: timestamps and captures per-cycle records around a trigger,
// then drains them oldest-first with a one-cycle-latency pop port.
module trace_capture #(
  parameter int unsigned REC_W = 105,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned TS_W  = 16
) (
  input logic              clk,
  input logic              rst,
  trace_capture_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = TS_W + REC_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q,    state_d;
  logic [1:0]        mode_q,     mode_d;
  logic [AW-1:0]     post_q,     post_d;
  logic [TS_W-1:0]   ts_q,       ts_d;
  logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [CW-1:0]     count_q,    count_d;
  logic              overflow_q, overflow_d;
  logic [DW-1:0]     rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_empty_q, rd_empty_d;
  logic [REC_W-1:0]  last_q,     last_d;
  logic              first_q,    first_d;

  logic              wr_en_c;
  logic              qual_c;
  logic              full_c;
  logic [DW-1:0]     mem [DEPTH];

  // Change-only mode drops repeats of the last captured record; the first after arm always passes.
  assign qual_c = bus.rec_valid &&
                  ((mode_q != 2'd2) || first_q || (bus.rec_data != last_q));
  assign full_c = (count_q == CW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    post_d     = post_q;
    ts_d       = ts_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    last_d     = last_q;
    first_d    = first_q;
    wr_en_c    = 1'b0;

    if (bus.arm) begin
      state_d    = S_ARMED;
      mode_d     = (bus.mode == 2'd3) ? 2'd0 : bus.mode;
      post_d     = bus.post_cnt;
      ts_d       = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      first_d    = 1'b1;
    end else begin
      case (state_q)
        S_ARMED, S_POST: begin
          ts_d = ts_q + TS_W'(1);
          if (state_q == S_ARMED && mode_q == 2'd1) begin
            // One-shot: stop once full, never overwrite.
            if (full_c) state_d = S_DONE;
            else        wr_en_c = qual_c;
          end else begin
            wr_en_c = qual_c;
            if (state_q == S_ARMED) begin
              if (bus.trig) state_d = (post_q == '0) ? S_DONE : S_POST;
            end else if (qual_c) begin
              post_d = post_q - AW'(1);
              if (post_q == AW'(1)) state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.rd_en && count_q != '0) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + AW'(1);
            count_d    = count_q - CW'(1);
          end
        end
        default: ;
      endcase

      if (wr_en_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        last_d   = bus.rec_data;
        first_d  = 1'b0;
        // Overwrite keeps the read pointer on the oldest surviving entry.
        if (full_c) begin
          overflow_d = 1'b1;
          rd_ptr_d   = wr_ptr_q + AW'(1);
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end

    rd_empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      post_q     <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_empty_q <= 1'b1;
      last_q     <= '0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      post_q     <= post_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_empty_q <= rd_empty_d;
      last_q     <= last_d;
      first_q    <= first_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr_q] <= {ts_q, bus.rec_data};
  end

  assign bus.state    = state_q;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_empty = rd_empty_q;
endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
Synthesizable on-chip trace buffer for cpu_top. It captures per-cycle bus records (PC, instruction, dmem we/addr/data) into a circular RAM. Each record is tagged with a timestamp. Capture supports three modes and a trigger with a programmable post-trigger count, so traces can be taken on silicon and by benches without a simulator-only dump. Readout is oldest-first through a pop interface with one-cycle read latency.

Parameters:
REC_W, 105, width of one captured record (rec_data)
DEPTH, 256, number of buffer entries; power of 2, >= 4
TS_W, 16, timestamp width; wraps modulo 2^TS_W
AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
arm  input  1  pulse: clear buffer/timestamp, enter ARMED
mode  input  2  0=trigger-circular, 1=one-shot fill, 2=change-only circular, 3=reserved (treated as 0); sampled on arm
post_cnt  input  AW  records to capture after trigger record; sampled on arm
rec_valid  input  1  rec_data qualifies for capture this cycle
rec_data  input  REC_W  record to capture
trig  input  1  trigger event
rd_en  input  1  pop oldest entry (honoured only in DONE, not empty)
rd_data  output  TS_W+REC_W  {timestamp, record} of popped entry
rd_valid  output  1  rd_data valid (one-cycle pulse)
rd_empty  output  1  no unread entries
count  output  AW+1  entries currently held
overflow  output  1  at least one entry was overwritten
state  output  2  0=IDLE, 1=ARMED, 2=POST, 3=DONE

Behaviour:
- Reset state: state=IDLE; count=0; overflow=0; rd_valid=0; rd_data=0; rd_empty=1. Pointers and timestamp are 0. RAM contents are don't-care.
- Timestamp: clears to 0 on arm and increments every cycle while in ARMED or POST. The stored value is the timestamp of the capture cycle.
- Capture condition (ARMED/POST): rec_valid=1, plus for mode 2 rec_data != last captured record. In mode 2 the first record after arm always qualifies.
- A write stores {ts, rec_data} at wr_ptr and then increments wr_ptr modulo DEPTH.
- count increments on each write and saturates at DEPTH.
- Writing while count==DEPTH overwrites the oldest entry and sets overflow (modes 0/2 only).
- IDLE: inputs other than arm are ignored.
- ARMED, modes 0/2: capture circularly. trig=1 enters POST.
  - A record qualifying in the trig cycle is captured and is the trigger record.
  - If post_cnt==0, go directly to DONE after that cycle.
- ARMED, mode 1: trig is ignored. Capture until count==DEPTH, then DONE on the next cycle. Never overwrite; overflow stays 0.
- POST: decrement the post counter on each captured record. On the write that reaches 0, go to DONE. Further trig pulses are ignored.
- DONE: no capture. rd_ptr starts at the oldest entry: wr_ptr if overflow=1, else 0.
  - rd_en with rd_empty=0 reads RAM[rd_ptr] and decrements count.
  - rd_data/rd_valid are registered and valid the cycle after rd_en.
  - rd_en while empty is ignored (no rd_valid).
  - rd_empty=(count==0). State stays DONE until arm.
- rd_en outside DONE is ignored.
- arm in any state (including mid-POST or mid-readout) restarts in ARMED. It clears count, pointers, overflow, ts and any pending rd_valid, and samples mode and post_cnt.
- arm and trig in the same cycle: arm wins and trig is ignored.
- Async rst mid-operation returns all outputs to their reset values immediately.
- Capture throughput is one record per cycle with no stall; the recording side has no back-pressure.

Test Plan:
- Reset: assert rst mid-POST -> immediately state=0, count=0, overflow=0, rd_valid=0, rd_empty=1.
- Mode 0, DEPTH=8, post_cnt=2, rec_valid every cycle, records 1..20, trig with record 10:
  - required: DONE after record 12; count=8; overflow=1.
  - pop 8 -> records 5..12 in order, timestamps strictly +1; then rd_empty=1, and extra rd_en gives no rd_valid.
- Mode 1, DEPTH=8, records 1..12, trig at record 3 -> trig ignored; DONE after record 8; overflow=0; readout 1..8.
- Mode 2, rec_data sequence A,A,A,B,B,C with rec_valid=1, trig on C, post_cnt=0 -> 3 entries A,B,C with timestamps 0,3,5.
- arm and trig same cycle -> state=ARMED (not POST), count=0. A re-arm during readout with 4 entries unread -> count=0, rd_empty=1, state=ARMED.
- Throughput: rec_valid toggling 1,0,1,0 with trig at post_cnt=3 -> exactly 3 post-trigger entries captured, with timestamps differing by 2.
